// File: rtl/sys_defs.sv
// Core-wide sizing shared by the ROB, RAT, dispatch and the free list.
// Also holds the free-list reset image and a popcount helper.
package sys_defs;

    localparam int N_WAY       = 3;
    localparam int N_PHYS_REG  = 64;
    localparam int N_ARCH_REG  = 32;
    localparam int N_ROB       = 32;
    localparam int CDB_BITS    = $clog2(N_PHYS_REG);
    localparam int ZERO_REG_PR = 0;

    localparam int COUNT_W = $clog2(N_PHYS_REG) + 1;
    localparam int AVAIL_W = $clog2(N_WAY) + 1;

    localparam logic [CDB_BITS-1:0] ZERO_TAG = CDB_BITS'(ZERO_REG_PR);

    // Arch reg i starts out mapped to PR i, so only the upper registers are free.
    function automatic logic [N_PHYS_REG-1:0] init_free_bits();
        logic [N_PHYS_REG-1:0] bits;
        bits = '0;
        for (int i = N_ARCH_REG; i < N_PHYS_REG; i++) begin
            bits[i] = 1'b1;
        end
        return bits;
    endfunction

    localparam logic [N_PHYS_REG-1:0] RESET_FREE_BITS = init_free_bits();

    function automatic logic [COUNT_W-1:0] popcount(input logic [N_PHYS_REG-1:0] bits);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_PHYS_REG; i++) begin
            cnt = cnt + COUNT_W'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/free_list_picker.sv
// Multi-grant priority selector: returns the lowest SLOTS set-bit indices of
// a vector, in ascending order, with a valid flag per slot.
module free_list_picker #(
    parameter int WIDTH = 64,
    parameter int SLOTS = 3,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]            vec,
    output logic [SLOTS-1:0][IDX_W-1:0] idx,
    output logic [SLOTS-1:0]            valid
);

    logic [WIDTH-1:0] remaining;

    // Each slot takes the lowest remaining bit, then removes it for later slots.
    always_comb begin
        remaining = vec;
        idx       = '0;
        valid     = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!valid[s] && remaining[i]) begin
                    valid[s] = 1'b1;
                    idx[s]   = IDX_W'(i);
                end
            end
            if (valid[s]) begin
                remaining[idx[s]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: grants up to N_WAY fresh tags per cycle and
// reclaims retired T_old tags and squashed tags on branch recovery.
module free_list
    import sys_defs::*;
(
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_WAY-1:0]                   alloc_req,
    output logic [N_WAY-1:0][CDB_BITS-1:0]     alloc_tag,
    output logic [N_WAY-1:0]                   alloc_valid,
    input  logic [N_WAY-1:0]                   retire_valid,
    input  logic [N_WAY-1:0][CDB_BITS-1:0]     retire_told,
    input  logic                               branch_haz,
    input  logic [N_ROB-1:0][CDB_BITS-1:0]     free_list_haz,
    output logic [COUNT_W-1:0]                 free_count,
    output logic [AVAIL_W-1:0]                 free_avail,
    output logic                               free_err
);

    logic [N_PHYS_REG-1:0]            free_bits;
    logic [N_PHYS_REG-1:0]            next_bits;
    logic                             next_err;
    logic [N_PHYS_REG-1:0]            pick_vec;
    logic [N_WAY-1:0][CDB_BITS-1:0]   pick_idx;
    logic [N_WAY-1:0]                 pick_valid;
    int                               slot;

    always_comb begin
        pick_vec              = free_bits;
        pick_vec[ZERO_REG_PR] = 1'b0;
    end

    free_list_picker #(
        .WIDTH (N_PHYS_REG),
        .SLOTS (N_WAY),
        .IDX_W (CDB_BITS)
    ) u_picker (
        .vec   (pick_vec),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Requesting ways consume picker slots in ascending order; recovery blocks all grants.
    always_comb begin
        alloc_valid = '0;
        alloc_tag   = '0;
        slot        = 0;
        for (int w = 0; w < N_WAY; w++) begin
            if (alloc_req[w] && !branch_haz && pick_valid[slot]) begin
                alloc_valid[w] = 1'b1;
                alloc_tag[w]   = pick_idx[slot];
                slot           = slot + 1;
            end
        end
    end

    // Frees are checked against the bitmap as it accumulates, so duplicates flag an error.
    always_comb begin
        next_bits = free_bits;
        next_err  = free_err;
        for (int i = 0; i < N_WAY; i++) begin
            if (retire_valid[i] && retire_told[i] != ZERO_TAG) begin
                if (next_bits[retire_told[i]]) next_err = 1'b1;
                else                           next_bits[retire_told[i]] = 1'b1;
            end
        end
        if (branch_haz) begin
            for (int k = 0; k < N_ROB; k++) begin
                if (free_list_haz[k] != ZERO_TAG) begin
                    if (next_bits[free_list_haz[k]]) next_err = 1'b1;
                    else                             next_bits[free_list_haz[k]] = 1'b1;
                end
            end
        end
        for (int w = 0; w < N_WAY; w++) begin
            if (alloc_valid[w]) next_bits[alloc_tag[w]] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_bits  <= RESET_FREE_BITS;
            free_count <= COUNT_W'(N_PHYS_REG - N_ARCH_REG);
            free_err   <= 1'b0;
        end else begin
            free_bits  <= next_bits;
            free_count <= popcount(next_bits);
            free_err   <= next_err;
        end
    end

    assign free_avail = (free_count >= COUNT_W'(N_WAY)) ? AVAIL_W'(N_WAY)
                                                        : free_count[AVAIL_W-1:0];

endmodule
